// File: rtl/systolic_pkg.sv
// Shared types and sizing for the 8x8 systolic array address path.
package systolic_pkg;

   localparam int ARRAY_DIM    = 8;
   localparam int SERIAL_W     = 7;
   localparam int STEP         = 4;
   localparam int DRAIN_CYCLES = 2 * ARRAY_DIM - 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } seq_state_t;

endpackage

// File: rtl/addr_seq_ctrl.sv
// Address sequencer: start -> serials 0,STEP,..<=last, drain, done pulse; all outputs registered, first issue 1 cycle after start.
// Stall freezes state/serial/drain count for that edge and drops addr_valid; start ignored while busy.
module addr_seq_ctrl #(
   parameter int SERIAL_W     = systolic_pkg::SERIAL_W,
   parameter int STEP         = systolic_pkg::STEP,
   parameter int DRAIN_CYCLES = systolic_pkg::DRAIN_CYCLES
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [SERIAL_W-1:0] last_serial,
   input  logic                stall,
   output logic [SERIAL_W-1:0] addr_serial_num,
   output logic                addr_valid,
   output logic                acc_clear,
   output logic                busy,
   output logic                done
);
   import systolic_pkg::*;

   localparam int                CNT_W    = $clog2(DRAIN_CYCLES + 1);
   localparam logic [SERIAL_W:0] STEP_EXT = (SERIAL_W + 1)'(STEP);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DRAIN_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   seq_state_t          state_q, state_d;
   logic [SERIAL_W-1:0] serial_q, serial_d;
   logic [SERIAL_W-1:0] last_q, last_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                valid_q, valid_d;
   logic                clear_q, clear_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [SERIAL_W:0]   serial_inc;
   logic                issue_end;

   // One extra bit so the step past the top of the serial range is seen, never wrapped.
   assign serial_inc = {1'b0, serial_q} + STEP_EXT;
   assign issue_end  = (serial_inc > {1'b0, last_q}) || serial_inc[SERIAL_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         serial_q <= '0;
         last_q   <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         clear_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         serial_q <= serial_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         clear_q  <= clear_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      serial_d = serial_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      valid_d  = 1'b0;
      clear_d  = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = ISSUE;
               serial_d = '0;
               last_d   = last_serial;
               valid_d  = 1'b1;
               clear_d  = 1'b1;
            end
         end
         ISSUE: begin
            if (!stall) begin
               if (issue_end) begin
                  // The transition edge counts as the first drain cycle.
                  state_d = DRAIN;
                  cnt_d   = CNT_ONE;
               end else begin
                  serial_d = serial_inc[SERIAL_W-1:0];
                  valid_d  = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (!stall) begin
               if (cnt_q == CNT_LAST) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   assign addr_serial_num = serial_q;
   assign addr_valid      = valid_q;
   assign acc_clear       = clear_q;
   assign busy            = busy_q;
   assign done            = done_q;

endmodule
